// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//
// ID->EX pipeline register of the 5-stage MIPS core. Each rising CLK edge it
// captures the main-decoder control bundle and the decode-stage data
// (register read data, specifiers, sign-extended immediate, PC+4) and
// presents the registered copy to the execute stage.
//
// Per-edge priority: Flush_E > Stall_E > load.
//   Flush_E=1            : every E-stage field and Valid_E become 0 (bubble).
//   Flush_E=0, Stall_E=1 : every E-stage field and Valid_E are held.
//   both 0               : fields load from _D, Valid_E <= Valid_D; control
//                          bits (including ALUOp) are forced to 0 when
//                          Valid_D=0 so an invalid slot can never write state.
// RST is asynchronous and active-low; it clears every register at once.
// All outputs come straight from flops (no combinational _D -> _E path).
//
// Ports
//   CLK, RST                        clock, async active-low reset
//   Stall_E, Flush_E                hazard-unit hold / bubble requests
//   Valid_D                         decode slot holds a real instruction
//   Jump_D .. RegWrite_D, ALUOp_D   main-decoder control bundle
//   RD1_D, RD2_D, SignImm_D,
//   PCPlus4_D, Rs_D, Rt_D, Rd_D     decode-stage data
//   <name>_E, Valid_E               registered copies for EX
//
// Optional feature, macro ID_EX_PERF_CNT_EN:
//   adds parameter CNT_WIDTH and ports Clr_Cnt (in), Bubble_Cnt and
//   Stall_Cnt (out). Bubble_Cnt counts flush edges, Stall_Cnt counts
//   stall-without-flush edges; both saturate at all-ones and Clr_Cnt zeroes
//   them on the next edge, taking precedence over any increment.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 2
`ifdef ID_EX_PERF_CNT_EN
   ,parameter int CNT_WIDTH      = 16
`endif
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Stall_E,
    input  logic                      Flush_E,
    input  logic                      Valid_D,
    input  logic                      Jump_D,
    input  logic                      MemtoReg_D,
    input  logic                      MemWrite_D,
    input  logic                      Branch_D,
    input  logic                      ALUSrc_D,
    input  logic                      RegDst_D,
    input  logic                      RegWrite_D,
    input  logic [ALU_OP_WIDTH-1:0]   ALUOp_D,
    input  logic [DATA_WIDTH-1:0]     RD1_D,
    input  logic [DATA_WIDTH-1:0]     RD2_D,
    input  logic [DATA_WIDTH-1:0]     SignImm_D,
    input  logic [DATA_WIDTH-1:0]     PCPlus4_D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs_D,
    input  logic [REG_ADDR_WIDTH-1:0] Rt_D,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_D,
    output logic                      Jump_E,
    output logic                      MemtoReg_E,
    output logic                      MemWrite_E,
    output logic                      Branch_E,
    output logic                      ALUSrc_E,
    output logic                      RegDst_E,
    output logic                      RegWrite_E,
    output logic [ALU_OP_WIDTH-1:0]   ALUOp_E,
    output logic [DATA_WIDTH-1:0]     RD1_E,
    output logic [DATA_WIDTH-1:0]     RD2_E,
    output logic [DATA_WIDTH-1:0]     SignImm_E,
    output logic [DATA_WIDTH-1:0]     PCPlus4_E,
    output logic [REG_ADDR_WIDTH-1:0] Rs_E,
    output logic [REG_ADDR_WIDTH-1:0] Rt_E,
    output logic [REG_ADDR_WIDTH-1:0] Rd_E,
    output logic                      Valid_E
`ifdef ID_EX_PERF_CNT_EN
   ,input  logic                      Clr_Cnt,
    output logic [CNT_WIDTH-1:0]      Bubble_Cnt,
    output logic [CNT_WIDTH-1:0]      Stall_Cnt
`endif
);

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    logic                      jump_q,      jump_d;
    logic                      memtoreg_q,  memtoreg_d;
    logic                      memwrite_q,  memwrite_d;
    logic                      branch_q,    branch_d;
    logic                      alusrc_q,    alusrc_d;
    logic                      regdst_q,    regdst_d;
    logic                      regwrite_q,  regwrite_d;
    logic [ALU_OP_WIDTH-1:0]   aluop_q,     aluop_d;
    logic [DATA_WIDTH-1:0]     rd1_q,       rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q,       rd2_d;
    logic [DATA_WIDTH-1:0]     signimm_q,   signimm_d;
    logic [DATA_WIDTH-1:0]     pcplus4_q,   pcplus4_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q,        rs_d;
    logic [REG_ADDR_WIDTH-1:0] rt_q,        rt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
    logic                      valid_q,     valid_d;

    // -----------------------------------------------------------------------
    // Next-state selection: flush, else hold on stall, else load.
    // -----------------------------------------------------------------------
    always_comb begin
        // Default: hold (covers the stall case)
        jump_d     = jump_q;
        memtoreg_d = memtoreg_q;
        memwrite_d = memwrite_q;
        branch_d   = branch_q;
        alusrc_d   = alusrc_q;
        regdst_d   = regdst_q;
        regwrite_d = regwrite_q;
        aluop_d    = aluop_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        signimm_d  = signimm_q;
        pcplus4_d  = pcplus4_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        valid_d    = valid_q;

        if (Flush_E) begin
            // Bubble: an all-zero control word is a NOP, data zeroed too.
            jump_d     = 1'b0;
            memtoreg_d = 1'b0;
            memwrite_d = 1'b0;
            branch_d   = 1'b0;
            alusrc_d   = 1'b0;
            regdst_d   = 1'b0;
            regwrite_d = 1'b0;
            aluop_d    = '0;
            rd1_d      = '0;
            rd2_d      = '0;
            signimm_d  = '0;
            pcplus4_d  = '0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            valid_d    = 1'b0;
        end else if (!Stall_E) begin
            // Control bits are qualified by Valid_D so that Valid_E=0 always
            // implies no architectural side effect in later stages.
            jump_d     = Jump_D     & Valid_D;
            memtoreg_d = MemtoReg_D & Valid_D;
            memwrite_d = MemWrite_D & Valid_D;
            branch_d   = Branch_D   & Valid_D;
            alusrc_d   = ALUSrc_D   & Valid_D;
            regdst_d   = RegDst_D   & Valid_D;
            regwrite_d = RegWrite_D & Valid_D;
            aluop_d    = Valid_D ? ALUOp_D : '0;
            // Data fields are captured regardless of validity.
            rd1_d      = RD1_D;
            rd2_d      = RD2_D;
            signimm_d  = SignImm_D;
            pcplus4_d  = PCPlus4_D;
            rs_d       = Rs_D;
            rt_d       = Rt_D;
            rd_d       = Rd_D;
            valid_d    = Valid_D;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            jump_q     <= 1'b0;
            memtoreg_q <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            alusrc_q   <= 1'b0;
            regdst_q   <= 1'b0;
            regwrite_q <= 1'b0;
            aluop_q    <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            signimm_q  <= '0;
            pcplus4_q  <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            jump_q     <= jump_d;
            memtoreg_q <= memtoreg_d;
            memwrite_q <= memwrite_d;
            branch_q   <= branch_d;
            alusrc_q   <= alusrc_d;
            regdst_q   <= regdst_d;
            regwrite_q <= regwrite_d;
            aluop_q    <= aluop_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            signimm_q  <= signimm_d;
            pcplus4_q  <= pcplus4_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
        end
    end

    assign Jump_E     = jump_q;
    assign MemtoReg_E = memtoreg_q;
    assign MemWrite_E = memwrite_q;
    assign Branch_E   = branch_q;
    assign ALUSrc_E   = alusrc_q;
    assign RegDst_E   = regdst_q;
    assign RegWrite_E = regwrite_q;
    assign ALUOp_E    = aluop_q;
    assign RD1_E      = rd1_q;
    assign RD2_E      = rd2_q;
    assign SignImm_E  = signimm_q;
    assign PCPlus4_E  = pcplus4_q;
    assign Rs_E       = rs_q;
    assign Rt_E       = rt_q;
    assign Rd_E       = rd_q;
    assign Valid_E    = valid_q;

`ifdef ID_EX_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Hazard performance counters (saturating)
    // -----------------------------------------------------------------------
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q,  stall_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (Clr_Cnt) begin
            bubble_cnt_d = '0;
            stall_cnt_d  = '0;
        end else begin
            if (Flush_E && (bubble_cnt_q != '1))
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            // A stall masked by a flush is counted as a bubble only.
            if (!Flush_E && Stall_E && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign Bubble_Cnt = bubble_cnt_q;
    assign Stall_Cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 2;
    localparam int CW = 4;

    typedef struct packed {
        logic [6:0]    ctrl;   // {Jump,MemtoReg,MemWrite,Branch,ALUSrc,RegDst,RegWrite}
        logic [OW-1:0] aluop;
        logic          valid;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
    } pipe_t;

    // control bundle encodings (bit order as in pipe_t.ctrl)
    localparam logic [6:0] C_LW   = 7'b0100101; // MemtoReg, ALUSrc, RegWrite
    localparam logic [6:0] C_RTYP = 7'b0000011; // RegDst, RegWrite
    localparam logic [6:0] C_ADDI = 7'b0000101; // ALUSrc, RegWrite
    localparam logic [6:0] C_BEQ  = 7'b0001000; // Branch
    localparam logic [6:0] C_SWJ  = 7'b1010000; // Jump, MemWrite

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Stall_E = 1'b0, Flush_E = 1'b0, Valid_D = 1'b0;
    logic          Jump_D = 1'b0, MemtoReg_D = 1'b0, MemWrite_D = 1'b0, Branch_D = 1'b0;
    logic          ALUSrc_D = 1'b0, RegDst_D = 1'b0, RegWrite_D = 1'b0;
    logic [OW-1:0] ALUOp_D = '0;
    logic [DW-1:0] RD1_D = '0, RD2_D = '0, SignImm_D = '0, PCPlus4_D = '0;
    logic [AW-1:0] Rs_D = '0, Rt_D = '0, Rd_D = '0;
    logic          Jump_E, MemtoReg_E, MemWrite_E, Branch_E, ALUSrc_E, RegDst_E, RegWrite_E;
    logic [OW-1:0] ALUOp_E;
    logic [DW-1:0] RD1_E, RD2_E, SignImm_E, PCPlus4_E;
    logic [AW-1:0] Rs_E, Rt_E, Rd_E;
    logic          Valid_E;
`ifdef ID_EX_PERF_CNT_EN
    logic          Clr_Cnt = 1'b0;
    logic [CW-1:0] Bubble_Cnt, Stall_Cnt;
`endif

    always #5 CLK = ~CLK;

    id_ex_pipe_reg #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .ALU_OP_WIDTH(OW)
`ifdef ID_EX_PERF_CNT_EN
       ,.CNT_WIDTH(CW)
`endif
    ) dut (
        .CLK(CLK), .RST(RST), .Stall_E(Stall_E), .Flush_E(Flush_E), .Valid_D(Valid_D),
        .Jump_D(Jump_D), .MemtoReg_D(MemtoReg_D), .MemWrite_D(MemWrite_D),
        .Branch_D(Branch_D), .ALUSrc_D(ALUSrc_D), .RegDst_D(RegDst_D),
        .RegWrite_D(RegWrite_D), .ALUOp_D(ALUOp_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .SignImm_D(SignImm_D), .PCPlus4_D(PCPlus4_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
        .Jump_E(Jump_E), .MemtoReg_E(MemtoReg_E), .MemWrite_E(MemWrite_E),
        .Branch_E(Branch_E), .ALUSrc_E(ALUSrc_E), .RegDst_E(RegDst_E),
        .RegWrite_E(RegWrite_E), .ALUOp_E(ALUOp_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .SignImm_E(SignImm_E), .PCPlus4_E(PCPlus4_E), .Rs_E(Rs_E), .Rt_E(Rt_E), .Rd_E(Rd_E),
        .Valid_E(Valid_E)
`ifdef ID_EX_PERF_CNT_EN
       ,.Clr_Cnt(Clr_Cnt), .Bubble_Cnt(Bubble_Cnt), .Stall_Cnt(Stall_Cnt)
`endif
    );

    pipe_t obs;
    assign obs = {Jump_E, MemtoReg_E, MemWrite_E, Branch_E, ALUSrc_E, RegDst_E, RegWrite_E,
                  ALUOp_E, Valid_E, RD1_E, RD2_E, SignImm_E, PCPlus4_E, Rs_E, Rt_E, Rd_E};

    int    checks = 0;
    int    errors = 0;
    int    txn    = 0;
    pipe_t model  = '0;
    pipe_t sb[$];
    logic [CW-1:0] bub_exp = '0;
    logic [CW-1:0] stl_exp = '0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic [6:0] c, input logic [OW-1:0] op, input logic v,
                         input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                         input logic [DW-1:0] im, input logic [DW-1:0] pc,
                         input logic [AW-1:0] s, input logic [AW-1:0] t, input logic [AW-1:0] d);
        {Jump_D, MemtoReg_D, MemWrite_D, Branch_D, ALUSrc_D, RegDst_D, RegWrite_D} = c;
        ALUOp_D = op; Valid_D = v;
        RD1_D = r1; RD2_D = r2; SignImm_D = im; PCPlus4_D = pc;
        Rs_D = s; Rt_D = t; Rd_D = d;
    endtask

    // One clock edge: compute the expected E-stage word from current inputs,
    // queue it, let the edge happen, then pop and compare.
    task automatic step(input string tag);
        pipe_t e;
        pipe_t got;
        if (Flush_E) begin
            e = '0;
        end else if (Stall_E) begin
            e = model;
        end else begin
            e.ctrl  = Valid_D ? {Jump_D, MemtoReg_D, MemWrite_D, Branch_D,
                                 ALUSrc_D, RegDst_D, RegWrite_D} : 7'b0;
            e.aluop = Valid_D ? ALUOp_D : '0;
            e.valid = Valid_D;
            e.rd1 = RD1_D; e.rd2 = RD2_D; e.imm = SignImm_D; e.pc4 = PCPlus4_D;
            e.rs = Rs_D; e.rt = Rt_D; e.rd = Rd_D;
        end
        model = e;
        sb.push_back(e);
`ifdef ID_EX_PERF_CNT_EN
        if (Clr_Cnt) begin
            bub_exp = '0;
            stl_exp = '0;
        end else begin
            if (Flush_E && bub_exp != 4'hF) bub_exp = bub_exp + 4'd1;
            if (!Flush_E && Stall_E && stl_exp != 4'hF) stl_exp = stl_exp + 4'd1;
        end
`endif
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        check({tag, ".e_word"}, 256'(obs), 256'(got));
        // An invalid E slot must never carry state-changing controls.
        check({tag, ".inv_ctrl"},
              256'({RegWrite_E, MemWrite_E, Branch_E, Jump_E} & {4{~Valid_E}}), 256'(0));
`ifdef ID_EX_PERF_CNT_EN
        check({tag, ".bubble_cnt"}, 256'(Bubble_Cnt), 256'(bub_exp));
        check({tag, ".stall_cnt"},  256'(Stall_Cnt),  256'(stl_exp));
`endif
        txn++;
        $display("TXN %0d %s flush=%b stall=%b valid_d=%b -> valid_e=%b ctrl_e=%b aluop_e=%b rd1_e=%h",
                 txn, tag, Flush_E, Stall_E, Valid_D, Valid_E, obs.ctrl, ALUOp_E, RD1_E);
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_state", 256'(obs), 256'(0));
        @(posedge CLK); #1;
        RST = 1'b1;

        // Pass-through of a lw
        set_d(C_LW, 2'b00, 1'b1, 32'h10, 32'h20, 32'h4, 32'h104, 5'd1, 5'd2, 5'd3);
        step("lw_pass");
        check("lw_valid_e", 256'(Valid_E), 256'(1));

        // Stall: R-type loaded, held 3 edges while addi waits on _D
        set_d(C_RTYP, 2'b10, 1'b1, 32'hA5A5_0001, 32'h5A5A_0002, 32'h0, 32'h108, 5'd4, 5'd5, 5'd6);
        step("rtype_load");
        set_d(C_ADDI, 2'b00, 1'b1, 32'h0000_0033, 32'h0, 32'hFFFF_FFF0, 32'h10C, 5'd7, 5'd8, 5'd0);
        Stall_E = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            check("stall_regdst", 256'(RegDst_E), 256'(1));
            check("stall_aluop",  256'(ALUOp_E),  256'(2'b10));
        end
        Stall_E = 1'b0;
        step("addi_after_stall");
        check("addi_imm", 256'(SignImm_E), 256'(32'hFFFF_FFF0));

        // Flush wins over stall with a beq on _D
        set_d(C_BEQ, 2'b01, 1'b1, 32'h11, 32'h11, 32'h8, 32'h110, 5'd9, 5'd9, 5'd0);
        Stall_E = 1'b1; Flush_E = 1'b1;
        step("flush_over_stall");
        check("flush_branch", 256'(Branch_E), 256'(0));
        Stall_E = 1'b0; Flush_E = 1'b0;

        // Invalid decode slot: data captured, controls forced to zero
        set_d(C_SWJ, 2'b11, 1'b0, 32'hCAFE_0000, 32'h1234_5678, 32'h40, 32'h114, 5'd10, 5'd11, 5'd12);
        step("invalid_slot");
        check("invalid_memwrite", 256'(MemWrite_E), 256'(0));

        // A few random transactions, mixed stall/flush/valid
        for (int i = 0; i < 12; i++) begin
            set_d(7'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                  $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
            Stall_E = ($urandom_range(0, 3) == 0);
            Flush_E = ($urandom_range(0, 5) == 0);
            step("random");
        end
        Stall_E = 1'b0; Flush_E = 1'b0;

`ifdef ID_EX_PERF_CNT_EN
        // Bubble counter saturates, clear overrides increment
        Flush_E = 1'b1;
        for (int i = 0; i < 20; i++) step("flush_sat");
        check("bubble_sat", 256'(Bubble_Cnt), 256'(4'hF));
        Clr_Cnt = 1'b1;
        step("clr_with_flush");
        check("bubble_clr", 256'(Bubble_Cnt), 256'(0));
        Clr_Cnt = 1'b0; Flush_E = 1'b0;
        Stall_E = 1'b1;
        for (int i = 0; i < 3; i++) step("stall_cnt");
        Stall_E = 1'b0;
`endif

        // Asynchronous reset mid-cycle, while stalled with live data on _D
        set_d(7'b0000001, 2'b00, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 5'd1, 5'd1, 5'd1);
        step("pre_reset_load");
        Stall_E = 1'b1;
        #2;
        RST = 1'b0;
        #1;
        check("async_reset", 256'(obs), 256'(0));
`ifdef ID_EX_PERF_CNT_EN
        check("async_reset_cnt", 256'({Bubble_Cnt, Stall_Cnt}), 256'(0));
        bub_exp = '0; stl_exp = '0;
`endif
        model = '0;
        @(posedge CLK); #1;
        check("reset_held_over_edge", 256'(obs), 256'(0));
        RST = 1'b1;
        Stall_E = 1'b0;
        step("first_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
